// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - data memory with byte-lane RAM, misaligned-store flag and optional MMIO block (DMEM_MMIO_EN)
module dmem_unit #(
    parameter int WORDS_LOG2 = 10,
    parameter int TXQ_DEPTH  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Dmem_addr,
    input  logic [7:0]  Dmem_data_wr1,
    input  logic [7:0]  Dmem_data_wr2,
    input  logic [7:0]  Dmem_data_wr3,
    input  logic [7:0]  Dmem_data_wr4,
    input  logic [1:0]  Dmem_write_en,
    output logic [31:0] Dmem_data_read,
    output logic [7:0]  Tx_data,
    output logic        Tx_valid,
    input  logic        Tx_ready,
    output logic        Misalign_err
);

    localparam int WORDS = 1 << WORDS_LOG2;

    logic [31:0]           ram_q [WORDS];
    logic [WORDS_LOG2-1:0] word_idx;
    logic [31:0]           wr_word;
    logic [31:0]           ram_rd;
    logic [3:0]            lane_strb;
    logic [3:0]            ram_we;
    logic                  is_store;
    logic                  misaligned;
    logic                  is_mmio;
    logic                  status_wr;
    logic                  misalign_d, misalign_q;

    assign word_idx = Dmem_addr[WORDS_LOG2+1:2];
    assign wr_word  = {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1};
    assign ram_rd   = ram_q[word_idx];
    assign is_store = |Dmem_write_en;

    always_comb begin
        lane_strb  = 4'b0000;
        misaligned = 1'b0;
        case (Dmem_write_en)
            2'b01: lane_strb = 4'b0001 << Dmem_addr[1:0];
            2'b10: begin
                lane_strb  = Dmem_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = Dmem_addr[0];
            end
            2'b11: begin
                lane_strb  = 4'b1111;
                misaligned = |Dmem_addr[1:0];
            end
            default: lane_strb = 4'b0000;
        endcase
    end

    // Misaligned stores are dropped whole; reset also discards the in-flight write.
    assign ram_we = lane_strb & {4{is_store && !is_mmio && !misaligned && !Reset}};

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) begin
                ram_q[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_comb begin
        misalign_d = misalign_q | (is_store && !is_mmio && misaligned);
        if (status_wr) begin
            misalign_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign Misalign_err = misalign_q;

`ifdef DMEM_MMIO_EN
    localparam int PW = $clog2(TXQ_DEPTH);
    localparam logic [PW:0]  TXQ_FULL     = (PW+1)'(TXQ_DEPTH);
    localparam logic [29:0]  A_CYCLE_LO   = 30'h2000_0000;
    localparam logic [29:0]  A_CYCLE_HI   = 30'h2000_0001;
    localparam logic [29:0]  A_TXDATA     = 30'h2000_0002;
    localparam logic [29:0]  A_STATUS     = 30'h2000_0003;

    logic [63:0]   cycle_d, cycle_q;
    logic [7:0]    txq_q [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr_d, wr_ptr_q;
    logic [PW-1:0] rd_ptr_d, rd_ptr_q;
    logic [PW:0]   count_d, count_q;
    logic          overflow_d, overflow_q;
    logic          txq_full, txq_empty;
    logic          push_req, push, pop;
    logic [29:0]   mmio_word;

    assign is_mmio   = Dmem_addr[31];
    assign mmio_word = Dmem_addr[31:2];
    assign status_wr = is_store && (mmio_word == A_STATUS);
    assign txq_full  = (count_q == TXQ_FULL);
    assign txq_empty = (count_q == '0);
    assign pop       = !txq_empty && Tx_ready;
    assign push_req  = is_store && (mmio_word == A_TXDATA);
    // A simultaneous pop frees a slot, so a push into a full queue still lands.
    assign push      = push_req && (!txq_full || pop);

    always_comb begin
        cycle_d    = cycle_q + 64'd1;
        wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, push};
        rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, pop};
        count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        overflow_d = overflow_q | (push_req && !push);
        if (status_wr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            txq_q[wr_ptr_q] <= Dmem_data_wr1;
        end
    end

    assign Tx_valid = !txq_empty;
    assign Tx_data  = txq_empty ? 8'h00 : txq_q[rd_ptr_q];

    always_comb begin
        Dmem_data_read = ram_rd;
        if (is_mmio) begin
            case (mmio_word)
                A_CYCLE_LO: Dmem_data_read = cycle_q[31:0];
                A_CYCLE_HI: Dmem_data_read = cycle_q[63:32];
                A_STATUS:   Dmem_data_read = {28'd0, misalign_q, overflow_q, txq_empty, txq_full};
                default:    Dmem_data_read = 32'd0;
            endcase
        end
    end

    logic unused_addr_hi;
    assign unused_addr_hi = ^Dmem_addr[30:WORDS_LOG2+2];
`else
    assign is_mmio        = 1'b0;
    assign status_wr      = 1'b0;
    assign Tx_valid       = 1'b0;
    assign Tx_data        = 8'h00;
    assign Dmem_data_read = ram_rd;

    logic unused_mmio_inputs;
    assign unused_mmio_inputs = ^{Dmem_addr[31:WORDS_LOG2+2], Tx_ready};
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - directed scoreboard bench for dmem_unit (RAM path always, MMIO path when DMEM_MMIO_EN)
module tb_dmem_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Dmem_addr;
    logic [7:0]  Dmem_data_wr1, Dmem_data_wr2, Dmem_data_wr3, Dmem_data_wr4;
    logic [1:0]  Dmem_write_en;
    logic [31:0] Dmem_data_read;
    logic [7:0]  Tx_data;
    logic        Tx_valid;
    logic        Tx_ready;
    logic        Misalign_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_model[$];

    dmem_unit dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Dmem_addr      (Dmem_addr),
        .Dmem_data_wr1  (Dmem_data_wr1),
        .Dmem_data_wr2  (Dmem_data_wr2),
        .Dmem_data_wr3  (Dmem_data_wr3),
        .Dmem_data_wr4  (Dmem_data_wr4),
        .Dmem_write_en  (Dmem_write_en),
        .Dmem_data_read (Dmem_data_read),
        .Tx_data        (Tx_data),
        .Tx_valid       (Tx_valid),
        .Tx_ready       (Tx_ready),
        .Misalign_err   (Misalign_err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] we, input logic [31:0] data);
        Dmem_addr     = addr;
        Dmem_write_en = we;
        {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = data;
        tick();
        Dmem_write_en = 2'b00;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Dmem_write_en = 2'b00;
        Dmem_addr     = addr;
        exp_q.push_back(exp);
        #1;
        check(tag, Dmem_data_read, exp_q.pop_front());
    endtask

    initial begin
        Reset         = 1'b1;
        Dmem_addr     = '0;
        Dmem_write_en = 2'b00;
        Tx_ready      = 1'b0;
        {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = '0;
        tick();
        tick();
        Reset = 1'b0;

        check("reset_misalign", {31'd0, Misalign_err}, 32'd0);
        check("reset_tx_valid", {31'd0, Tx_valid}, 32'd0);
        check("reset_tx_data", {24'd0, Tx_data}, 32'd0);

`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 10; i++) tick();
        read_chk("cycle_lo_10", 32'h8000_0000, 32'd10);
        read_chk("cycle_hi_0", 32'h8000_0004, 32'd0);
        read_chk("status_reset", 32'h8000_000C, 32'h0000_0002);
        read_chk("mmio_unmapped", 32'h8000_0010, 32'd0);
`endif

        store(32'h0000_0010, 2'b11, 32'hDEAD_BEEF);
        Dmem_addr     = 32'h0000_0012;
        Dmem_write_en = 2'b01;
        {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = 32'h0055_0000;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        check("read_during_write", Dmem_data_read, exp_q.pop_front());
        tick();
        read_chk("byte_merge", 32'h0000_0010, 32'hDE55_BEEF);
        read_chk("alias_bit12", 32'h0000_1010, 32'hDE55_BEEF);

        store(32'h0000_0030, 2'b11, 32'h1122_3344);
        store(32'h0000_0032, 2'b10, 32'hABCD_0000);
        read_chk("half_upper", 32'h0000_0030, 32'hABCD_3344);

        store(32'h0000_0020, 2'b11, 32'hCAFE_F00D);
        check("misalign_clear_before", {31'd0, Misalign_err}, 32'd0);
        store(32'h0000_0021, 2'b10, 32'h9999_9999);
        check("misalign_half_set", {31'd0, Misalign_err}, 32'd1);
        read_chk("misalign_half_nowrite", 32'h0000_0020, 32'hCAFE_F00D);
        store(32'h0000_0022, 2'b11, 32'h7777_7777);
        read_chk("misalign_word_nowrite", 32'h0000_0020, 32'hCAFE_F00D);
`ifdef DMEM_MMIO_EN
        read_chk("status_misalign", 32'h8000_000C, 32'h0000_000A);
        store(32'h8000_000C, 2'b11, 32'd0);
        check("misalign_cleared", {31'd0, Misalign_err}, 32'd0);
`else
        store(32'h8000_0008, 2'b11, 32'h1234_5678);
        read_chk("no_mmio_alias", 32'h0000_0008, 32'h1234_5678);
        check("no_mmio_tx_valid", {31'd0, Tx_valid}, 32'd0);
`endif

        store(32'h0000_0040, 2'b11, 32'h0BAD_F00D);
        store(32'h0000_0041, 2'b11, 32'h0);
        Reset = 1'b1;
        store(32'h0000_0040, 2'b11, 32'h1111_1111);
        Reset = 1'b0;
        read_chk("reset_discards_write", 32'h0000_0040, 32'h0BAD_F00D);
        check("reset_clears_misalign", {31'd0, Misalign_err}, 32'd0);

`ifdef DMEM_MMIO_EN
        Tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (tx_model.size() < 8) tx_model.push_back(8'(i));
            store(32'h8000_0008, 2'b01, 32'(i));
        end
        read_chk("status_full_ovf", 32'h8000_000C, 32'h0000_0005);
        check("tx_head_01", {24'd0, Tx_data}, {24'd0, tx_model[0]});
        store(32'h8000_000C, 2'b01, 32'd0);
        read_chk("status_ovf_cleared", 32'h8000_000C, 32'h0000_0001);

        Tx_ready      = 1'b1;
        Dmem_addr     = 32'h8000_0008;
        Dmem_write_en = 2'b01;
        {Dmem_data_wr4, Dmem_data_wr3, Dmem_data_wr2, Dmem_data_wr1} = 32'h0000_00AA;
        #1;
        check("tx_pop_push_head", {24'd0, Tx_data}, {24'd0, tx_model.pop_front()});
        tx_model.push_back(8'hAA);
        tick();
        Dmem_write_en = 2'b00;
        Tx_ready      = 1'b0;
        read_chk("status_full_no_ovf", 32'h8000_000C, 32'h0000_0001);

        Tx_ready = 1'b1;
        for (int i = 0; i < 40 && tx_model.size() > 0; i++) begin
            #1;
            if (Tx_valid) check("tx_order", {24'd0, Tx_data}, {24'd0, tx_model.pop_front()});
            tick();
        end
        Tx_ready = 1'b0;
        check("tx_drained", 32'(tx_model.size()), 32'd0);
        check("tx_valid_empty", {31'd0, Tx_valid}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter: WORDS_LOG2, default 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
REQ-002 Parameter: TXQ_DEPTH, default 8, TX queue entries (power of two, minimum 2).
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 Dmem_addr  input  32  byte address from core MEM stage.
REQ-006 Dmem_data_wr1..Dmem_data_wr4  input  8 each  write bytes for lanes 0..3 (lane 0 = bits 7:0), already lane-positioned by core.
REQ-007 Dmem_write_en  input  2  00 none, 01 byte, 10 halfword, 11 word.
REQ-008 Dmem_data_read  output  32  read data for Dmem_addr.
REQ-009 Tx_data  output  8  head of TX queue.
REQ-010 Tx_valid  output  1  TX queue non-empty.
REQ-011 Tx_ready  input  1  consumer accepts head when Tx_valid && Tx_ready at posedge.
REQ-012 Misalign_err  output  1  sticky misaligned-store flag.

Function
REQ-013 Region decode: Dmem_addr[31]=0 selects RAM (word index Dmem_addr[WORDS_LOG2+1:2], upper bits ignored, aliasing); Dmem_addr[31]=1 selects MMIO.
REQ-014 RAM read combinational: Dmem_data_read = word at index in same cycle (zero-latency, matches core's single-cycle memory model).
REQ-015 RAM write at posedge; byte strobes: byte -> lane Dmem_addr[1:0]; halfword -> lanes {1,0} or {3,2} by Dmem_addr[1]; word -> all lanes.
REQ-016 Same-cycle read and write of one word: Dmem_data_read returns pre-write contents.
REQ-017 Misaligned store (halfword with addr[0]=1, word with addr[1:0]!=0) suppresses the entire write and sets Misalign_err next cycle.
REQ-018 MMIO map: 0x8000_0000 CYCLE_LO (RO), 0x8000_0004 CYCLE_HI (RO), 0x8000_0008 TXDATA (WO), 0x8000_000C STATUS; other MMIO reads return 0, other MMIO writes ignored.
REQ-019 Cycle counter: 64 bits, +1 every cycle after reset, wraps 2^64-1 -> 0; CYCLE_HI reads live value (no snapshot).
REQ-020 Store of any width to TXDATA pushes Dmem_data_wr1 if queue not full; if full, byte dropped and overflow flag set.
REQ-021 STATUS read: bit0 full, bit1 empty, bit2 overflow, bit3 Misalign_err, others 0; any write to STATUS clears overflow and Misalign_err (clear wins over same-cycle set).
REQ-022 Queue FIFO order; push and pop same cycle when full: both occur, count unchanged, no overflow.
REQ-023 Push into empty queue: Tx_valid rises the cycle after the push (no bypass).
REQ-024 Pointers wrap modulo TXQ_DEPTH; count width log2(TXQ_DEPTH)+1.
REQ-025 MMIO stores ignore the alignment check of REQ-017.

Reset
REQ-026 On Reset: cycle counter 0, queue empty (Tx_valid 0, Tx_data 0), overflow 0, Misalign_err 0; RAM contents not reset.
REQ-027 Reset mid-operation: in-flight write and push that cycle discarded; reset overrides every same-cycle event.

Configuration
REQ-028 Macro DMEM_MMIO_EN: defined -> MMIO, cycle counter and TX queue present per REQ-018..025.
REQ-029 Without DMEM_MMIO_EN: Dmem_addr[31] ignored, all accesses go to RAM, Tx_valid and Tx_data tied 0, counter and queue not synthesized; Misalign_err retained.

Verification
REQ-030 Word store 0xDEADBEEF at 0x10, then byte store 0x55 at 0x12 -> read 0x10 returns 0xDE55BEEF.
REQ-031 Halfword store at 0x21 -> RAM word 0x20 unchanged, Misalign_err=1 next cycle; write STATUS -> Misalign_err=0.
REQ-032 Reset released, read CYCLE_LO 10 cycles later -> 10; CYCLE_HI -> 0.
REQ-033 Tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS=0x5 (full, overflow), Tx_data=0x01; Tx_ready=1 -> 0x01..0x08 in order, then Tx_valid=0.
REQ-034 Full queue, push 0xAA with Tx_ready=1 same cycle -> no overflow, 0xAA delivered last.
REQ-035 Build without DMEM_MMIO_EN, word store 0x12345678 to 0x8000_0008 -> read 0x0000_0008 returns 0x12345678, Tx_valid stays 0.
